// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, issues req/ack fetches, applies branch prediction, and
// feeds the IF/ID register through a one-entry skid buffer under decode stalls.
module instruction_fetch #(
    parameter logic [15:0] RESET_PC        = 16'h0000,
    parameter logic [15:0] NOP_INSTRUCTION = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_hz,
    input  logic        flush_ex,
    input  logic [15:0] redirect_pc_ex,
    input  logic        branch_prediction_bp,
    input  logic [15:0] predicted_target_bp,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instruction_if,
    output logic [15:0] next_program_counter_if,
    output logic [15:0] pc_if,
    output logic        branch_prediction_if,
    output logic        valid_if
);

    typedef enum logic [1:0] {FETCH, WAIT, HOLD, DRAIN} state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] req_addr;
    logic [15:0] skid_instr;
    logic [15:0] skid_pc;
    logic        skid_pred;
    logic        skid_full;

    logic [15:0] fall_through;
    logic [15:0] next_pc;
    logic        capture;
    logic        unskid;

    // A request stays on the bus until acked; FETCH only starts one when decode can move.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc;
        if (!rst) begin
            case (state)
                FETCH:       imem_req = ~stall_hz & ~flush_ex;
                WAIT, DRAIN: begin
                    imem_req  = 1'b1;
                    imem_addr = req_addr;
                end
                default:     imem_req = 1'b0;
            endcase
        end
    end

    always_comb begin
        fall_through = imem_addr + 16'd1;
        next_pc      = branch_prediction_bp ? predicted_target_bp : fall_through;
        capture      = ~flush_ex & ~stall_hz & imem_req & imem_ack &
                       ((state == FETCH) | (state == WAIT));
        unskid       = ~flush_ex & ~stall_hz & (state == HOLD) & skid_full;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                   <= FETCH;
            pc                      <= RESET_PC;
            req_addr                <= RESET_PC;
            skid_instr              <= NOP_INSTRUCTION;
            skid_pc                 <= 16'h0000;
            skid_pred               <= 1'b0;
            skid_full               <= 1'b0;
            instruction_if          <= NOP_INSTRUCTION;
            next_program_counter_if <= 16'h0000;
            pc_if                   <= 16'h0000;
            branch_prediction_if    <= 1'b0;
            valid_if                <= 1'b0;
        end else begin
            if (flush_ex) begin
                pc        <= redirect_pc_ex;
                skid_full <= 1'b0;
                // An unacked request must still be drained before the redirect is fetched.
                if ((state == WAIT || state == DRAIN) && !imem_ack)
                    state <= DRAIN;
                else
                    state <= FETCH;
            end else begin
                case (state)
                    FETCH: begin
                        if (imem_req) begin
                            req_addr <= pc;
                            if (imem_ack)
                                pc <= next_pc;
                            else
                                state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (imem_ack) begin
                            pc <= next_pc;
                            if (stall_hz) begin
                                skid_instr <= imem_rdata;
                                skid_pc    <= req_addr;
                                skid_pred  <= branch_prediction_bp;
                                skid_full  <= 1'b1;
                                state      <= HOLD;
                            end else begin
                                state <= FETCH;
                            end
                        end
                    end
                    HOLD: begin
                        if (!stall_hz) begin
                            skid_full <= 1'b0;
                            state     <= FETCH;
                        end
                    end
                    DRAIN: begin
                        if (imem_ack)
                            state <= FETCH;
                    end
                    default: state <= FETCH;
                endcase
            end

            // IF/ID register: load, or insert a bubble whenever decode advances without a load.
            if (capture) begin
                instruction_if          <= imem_rdata;
                pc_if                   <= imem_addr;
                next_program_counter_if <= fall_through;
                branch_prediction_if    <= branch_prediction_bp;
                valid_if                <= 1'b1;
            end else if (unskid) begin
                instruction_if          <= skid_instr;
                pc_if                   <= skid_pc;
                next_program_counter_if <= skid_pc + 16'd1;
                branch_prediction_if    <= skid_pred;
                valid_if                <= 1'b1;
            end else if (flush_ex || !stall_hz) begin
                instruction_if <= NOP_INSTRUCTION;
                valid_if       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized
// run checked against a transaction-level model of the fetch stage.
module tb_instruction_fetch;

    localparam logic [15:0] NOP = 16'h7E00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_hz = 1'b0;
    logic        flush_ex = 1'b0;
    logic [15:0] redirect_pc_ex = 16'h0000;
    logic        branch_prediction_bp = 1'b0;
    logic [15:0] predicted_target_bp = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] instruction_if;
    logic [15:0] next_program_counter_if;
    logic [15:0] pc_if;
    logic        branch_prediction_if;
    logic        valid_if;

    int checks = 0;
    int errors = 0;

    instruction_fetch #(
        .RESET_PC        (16'h0000),
        .NOP_INSTRUCTION (NOP)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall_hz                (stall_hz),
        .flush_ex                (flush_ex),
        .redirect_pc_ex          (redirect_pc_ex),
        .branch_prediction_bp    (branch_prediction_bp),
        .predicted_target_bp     (predicted_target_bp),
        .imem_req                (imem_req),
        .imem_addr               (imem_addr),
        .imem_ack                (imem_ack),
        .imem_rdata              (imem_rdata),
        .instruction_if          (instruction_if),
        .next_program_counter_if (next_program_counter_if),
        .pc_if                   (pc_if),
        .branch_prediction_if    (branch_prediction_if),
        .valid_if                (valid_if)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Predictor stimulus: 0 = never taken, 1 = single directed address, 2 = pattern.
    int          pred_mode = 0;
    logic [15:0] pred_addr = 16'h0000;
    logic [15:0] pred_tgt  = 16'h0000;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] h;
        if (a == 16'h0000) return 16'h1022;
        if (a == 16'h0001) return 16'h3045;
        h = a * 16'h9E37;
        return h ^ 16'h5A5A;
    endfunction

    function automatic logic pred_of(input logic [15:0] a);
        if (pred_mode == 1) return (a == pred_addr);
        if (pred_mode == 2) return (a[2:0] == 3'd5);
        return 1'b0;
    endfunction

    function automatic logic [15:0] tgt_of(input logic [15:0] a);
        if (pred_mode == 1) return pred_tgt;
        if (pred_mode == 2) return {a[7:0], a[15:8]} ^ 16'h0013;
        return 16'h0000;
    endfunction

    // Transaction model: next PC, one outstanding request (possibly stale after a
    // redirect), one word parked while decode is stalled, and the IF/ID contents.
    logic [15:0] m_pc, m_req_addr;
    logic        m_busy, m_stale;
    logic        m_held, m_held_pred;
    logic [15:0] m_held_instr, m_held_pc;
    logic [15:0] m_instr, m_opc, m_npc;
    logic        m_pred, m_valid;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        pre_req;
    logic [15:0] pre_addr;

    task automatic model_reset();
        m_pc = 16'h0000; m_req_addr = 16'h0000; m_busy = 1'b0; m_stale = 1'b0;
        m_held = 1'b0; m_held_pred = 1'b0; m_held_instr = 16'h0000; m_held_pc = 16'h0000;
        m_instr = NOP; m_opc = 16'h0000; m_npc = 16'h0000; m_pred = 1'b0; m_valid = 1'b0;
    endtask

    task automatic model_bus(input logic s, input logic f);
        if (m_held) begin
            exp_req = 1'b0; exp_addr = m_pc;
        end else if (m_busy) begin
            exp_req = 1'b1; exp_addr = m_req_addr;
        end else begin
            exp_req = !s && !f; exp_addr = m_pc;
        end
    endtask

    task automatic model_edge(input logic s, input logic f, input logic [15:0] r,
                              input logic a, input logic [15:0] d,
                              input logic bp, input logic [15:0] tgt);
        if (f) begin
            m_pc = r; m_held = 1'b0; m_valid = 1'b0; m_instr = NOP;
            m_busy = exp_req && !a; m_stale = exp_req && !a;
            if (exp_req && !a) m_req_addr = exp_addr;
        end else if (exp_req && a) begin
            m_busy = 1'b0;
            if (m_stale) begin
                m_stale = 1'b0;
                if (!s) begin m_valid = 1'b0; m_instr = NOP; end
            end else begin
                m_pc = bp ? tgt : exp_addr + 16'd1;
                if (s) begin
                    m_held = 1'b1; m_held_instr = d; m_held_pc = exp_addr; m_held_pred = bp;
                end else begin
                    m_instr = d; m_opc = exp_addr; m_npc = exp_addr + 16'd1;
                    m_pred = bp; m_valid = 1'b1;
                end
            end
        end else if (exp_req) begin
            m_busy = 1'b1; m_req_addr = exp_addr;
            if (!s) begin m_valid = 1'b0; m_instr = NOP; end
        end else if (!s) begin
            if (m_held) begin
                m_instr = m_held_instr; m_opc = m_held_pc; m_npc = m_held_pc + 16'd1;
                m_pred = m_held_pred; m_valid = 1'b1; m_held = 1'b0;
            end else begin
                m_valid = 1'b0; m_instr = NOP;
            end
        end
    endtask

    // One clock: drive inputs just after an edge, act as memory/predictor, sample the
    // bus before the next edge, then advance the model; ends 1 time unit past the edge.
    task automatic step(input logic s, input logic f, input logic [15:0] r, input logic a);
        stall_hz = s; flush_ex = f; redirect_pc_ex = r;
        model_bus(s, f);
        imem_ack = a && exp_req;
        #1;
        branch_prediction_bp = pred_of(imem_addr);
        predicted_target_bp  = tgt_of(imem_addr);
        imem_rdata           = mem_word(imem_addr);
        #1;
        pre_req = imem_req; pre_addr = imem_addr;
        if (imem_ack)
            $display("fetch addr=%h data=%h pred=%0b stall=%0b flush=%0b",
                     imem_addr, imem_rdata, branch_prediction_bp, s, f);
        model_edge(s, f, r, imem_ack, imem_rdata, branch_prediction_bp, predicted_target_bp);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; stall_hz = 1'b0; flush_ex = 1'b0; imem_ack = 1'b0; pred_mode = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        stall_hz = 1'b0; flush_ex = 1'b0; imem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b want 0", imem_req); end
        checks++; if (instruction_if !== NOP) begin errors++; $display("FAIL rst_instr got %h want %h", instruction_if, NOP); end
        checks++; if (pc_if !== 16'h0000) begin errors++; $display("FAIL rst_pc got %h want 0000", pc_if); end
        checks++; if (next_program_counter_if !== 16'h0000) begin errors++; $display("FAIL rst_npc got %h want 0000", next_program_counter_if); end
        checks++; if (branch_prediction_if !== 1'b0) begin errors++; $display("FAIL rst_pred got %0b want 0", branch_prediction_if); end
        checks++; if (valid_if !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", valid_if); end
        rst = 1'b0;
        model_reset();
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        // Reset mid-request: the request must drop at once and IF/ID must clear.
        #2;
        rst = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_mid_req got %0b want 0", imem_req); end
        checks++; if (valid_if !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %0b want 0", valid_if); end
        checks++; if (instruction_if !== NOP) begin errors++; $display("FAIL rst_mid_instr got %h want %h", instruction_if, NOP); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++; if (pre_addr !== 16'h0000) begin errors++; $display("FAIL rst_restart_addr got %h want 0000", pre_addr); end
        checks++; if (instruction_if !== 16'h1022) begin errors++; $display("FAIL rst_restart_instr got %h want 1022", instruction_if); end
    endtask

    task automatic test_zero_wait();
        apply_reset();
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++; if (pre_req !== 1'b1 || pre_addr !== 16'h0000) begin errors++; $display("FAIL zw_bus0 got req=%0b addr=%h want 1 0000", pre_req, pre_addr); end
        checks++; if (instruction_if !== 16'h1022) begin errors++; $display("FAIL zw_instr0 got %h want 1022", instruction_if); end
        checks++; if (pc_if !== 16'h0000 || next_program_counter_if !== 16'h0001) begin errors++; $display("FAIL zw_pc0 got %h/%h want 0000/0001", pc_if, next_program_counter_if); end
        checks++; if (valid_if !== 1'b1 || branch_prediction_if !== 1'b0) begin errors++; $display("FAIL zw_flags0 got v=%0b p=%0b want 1 0", valid_if, branch_prediction_if); end
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++; if (pre_addr !== 16'h0001) begin errors++; $display("FAIL zw_addr1 got %h want 0001", pre_addr); end
        checks++; if (instruction_if !== 16'h3045 || valid_if !== 1'b1) begin errors++; $display("FAIL zw_instr1 got %h v=%0b want 3045 1", instruction_if, valid_if); end
        checks++; if (pc_if !== 16'h0001 || next_program_counter_if !== 16'h0002) begin errors++; $display("FAIL zw_pc1 got %h/%h want 0001/0002", pc_if, next_program_counter_if); end
    endtask

    task automatic test_wait_latency();
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b0, 16'h0000, 1'b0);
            checks++; if (pre_req !== 1'b1 || pre_addr !== 16'h0000) begin errors++; $display("FAIL wl_bus%0d got req=%0b addr=%h want 1 0000", k, pre_req, pre_addr); end
            checks++; if (valid_if !== 1'b0 || instruction_if !== NOP) begin errors++; $display("FAIL wl_bubble%0d got v=%0b i=%h want 0 %h", k, valid_if, instruction_if, NOP); end
        end
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++; if (pre_addr !== 16'h0000) begin errors++; $display("FAIL wl_ack_addr got %h want 0000", pre_addr); end
        checks++; if (valid_if !== 1'b1 || instruction_if !== 16'h1022) begin errors++; $display("FAIL wl_data got v=%0b i=%h want 1 1022", valid_if, instruction_if); end
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        checks++; if (pre_addr !== 16'h0001) begin errors++; $display("FAIL wl_next_addr got %h want 0001", pre_addr); end
        checks++; if (valid_if !== 1'b0) begin errors++; $display("FAIL wl_one_cycle got v=%0b want 0", valid_if); end
    endtask

    task automatic test_prediction();
        apply_reset();
        pred_mode = 1; pred_addr = 16'h0004; pred_tgt = 16'h0020;
        repeat (4) step(1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++; if (pre_addr !== 16'h0004) begin errors++; $display("FAIL bp_addr got %h want 0004", pre_addr); end
        checks++; if (branch_prediction_if !== 1'b1) begin errors++; $display("FAIL bp_pred got %0b want 1", branch_prediction_if); end
        checks++; if (next_program_counter_if !== 16'h0005 || pc_if !== 16'h0004) begin errors++; $display("FAIL bp_pc got %h/%h want 0004/0005", pc_if, next_program_counter_if); end
        checks++; if (instruction_if !== mem_word(16'h0004)) begin errors++; $display("FAIL bp_instr got %h want %h", instruction_if, mem_word(16'h0004)); end
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++; if (pre_addr !== 16'h0020) begin errors++; $display("FAIL bp_target got %h want 0020", pre_addr); end
        checks++; if (pc_if !== 16'h0020 || branch_prediction_if !== 1'b0 || next_program_counter_if !== 16'h0021) begin errors++; $display("FAIL bp_after got pc=%h p=%0b npc=%h want 0020 0 0021", pc_if, branch_prediction_if, next_program_counter_if); end
        pred_mode = 0;
    endtask

    task automatic test_stall_skid();
        apply_reset();
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        checks++; if (pre_req !== 1'b0) begin errors++; $display("FAIL sk_fetch_stall_req got %0b want 0", pre_req); end
        checks++; if (valid_if !== 1'b1 || instruction_if !== 16'h1022 || pc_if !== 16'h0000) begin errors++; $display("FAIL sk_hold_valid got v=%0b i=%h pc=%h want 1 1022 0000", valid_if, instruction_if, pc_if); end
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 16'h0000, (k == 1));
            checks++; if (pre_req !== (k < 2)) begin errors++; $display("FAIL sk_req%0d got %0b want %0b", k, pre_req, (k < 2)); end
            if (k < 2) begin
                checks++; if (pre_addr !== 16'h0001) begin errors++; $display("FAIL sk_addr%0d got %h want 0001", k, pre_addr); end
            end
            checks++; if (valid_if !== 1'b0 || instruction_if !== NOP || pc_if !== 16'h0000 || next_program_counter_if !== 16'h0001) begin errors++; $display("FAIL sk_hold%0d got v=%0b i=%h pc=%h npc=%h want 0 %h 0000 0001", k, valid_if, instruction_if, pc_if, next_program_counter_if, NOP); end
        end
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        checks++; if (pre_req !== 1'b0) begin errors++; $display("FAIL sk_release_req got %0b want 0", pre_req); end
        checks++; if (valid_if !== 1'b1 || instruction_if !== 16'h3045 || pc_if !== 16'h0001 || next_program_counter_if !== 16'h0002) begin errors++; $display("FAIL sk_release got v=%0b i=%h pc=%h npc=%h want 1 3045 0001 0002", valid_if, instruction_if, pc_if, next_program_counter_if); end
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++; if (pre_addr !== 16'h0002 || instruction_if !== mem_word(16'h0002) || pc_if !== 16'h0002) begin errors++; $display("FAIL sk_resume got addr=%h i=%h pc=%h want 0002 %h 0002", pre_addr, instruction_if, pc_if, mem_word(16'h0002)); end
    endtask

    task automatic test_flush_drain();
        apply_reset();
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 16'h0100, 1'b0);
        checks++; if (pre_req !== 1'b1 || pre_addr !== 16'h0001) begin errors++; $display("FAIL fd_flush_bus got req=%0b addr=%h want 1 0001", pre_req, pre_addr); end
        checks++; if (valid_if !== 1'b0 || instruction_if !== NOP) begin errors++; $display("FAIL fd_flush_out got v=%0b i=%h want 0 %h", valid_if, instruction_if, NOP); end
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        checks++; if (pre_req !== 1'b1 || pre_addr !== 16'h0001) begin errors++; $display("FAIL fd_drain_bus got req=%0b addr=%h want 1 0001", pre_req, pre_addr); end
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++; if (pre_addr !== 16'h0001) begin errors++; $display("FAIL fd_drain_ack_addr got %h want 0001", pre_addr); end
        checks++; if (valid_if !== 1'b0 || instruction_if !== NOP || pc_if !== 16'h0000) begin errors++; $display("FAIL fd_dropped got v=%0b i=%h pc=%h want 0 %h 0000", valid_if, instruction_if, pc_if, NOP); end
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++; if (pre_addr !== 16'h0100) begin errors++; $display("FAIL fd_redirect_addr got %h want 0100", pre_addr); end
        checks++; if (valid_if !== 1'b1 || pc_if !== 16'h0100 || instruction_if !== mem_word(16'h0100)) begin errors++; $display("FAIL fd_redirect_data got v=%0b pc=%h i=%h want 1 0100 %h", valid_if, pc_if, instruction_if, mem_word(16'h0100)); end
    endtask

    task automatic test_flush_stall_wrap();
        apply_reset();
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 1'b1, 16'h0200, 1'b0);
        checks++; if (pre_req !== 1'b0) begin errors++; $display("FAIL fs_hold_req got %0b want 0", pre_req); end
        checks++; if (valid_if !== 1'b0 || instruction_if !== NOP) begin errors++; $display("FAIL fs_flush_out got v=%0b i=%h want 0 %h", valid_if, instruction_if, NOP); end
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        checks++; if (pre_req !== 1'b1 || pre_addr !== 16'h0200) begin errors++; $display("FAIL fs_redirect_bus got req=%0b addr=%h want 1 0200", pre_req, pre_addr); end
        checks++; if (valid_if !== 1'b0) begin errors++; $display("FAIL fs_skid_cleared got v=%0b want 0", valid_if); end
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++; if (pc_if !== 16'h0200 || instruction_if !== mem_word(16'h0200)) begin errors++; $display("FAIL fs_redirect_data got pc=%h i=%h want 0200 %h", pc_if, instruction_if, mem_word(16'h0200)); end
        step(1'b1, 1'b1, 16'hFFFF, 1'b0);
        checks++; if (valid_if !== 1'b0 || instruction_if !== NOP) begin errors++; $display("FAIL fs_flush_beats_stall got v=%0b i=%h want 0 %h", valid_if, instruction_if, NOP); end
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++; if (pre_addr !== 16'hFFFF || pc_if !== 16'hFFFF || next_program_counter_if !== 16'h0000) begin errors++; $display("FAIL fs_wrap got addr=%h pc=%h npc=%h want ffff ffff 0000", pre_addr, pc_if, next_program_counter_if); end
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++; if (pre_addr !== 16'h0000 || instruction_if !== 16'h1022) begin errors++; $display("FAIL fs_wrap_next got addr=%h i=%h want 0000 1022", pre_addr, instruction_if); end
    endtask

    task automatic test_random();
        logic s, f, a;
        logic [15:0] r;
        apply_reset();
        pred_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 15) == 0);
            a = ($urandom_range(0, 2) != 0);
            r = 16'($urandom());
            step(s, f, r, a);
            checks++; if (pre_req !== exp_req) begin errors++; $display("FAIL rnd_req cyc=%0d got %0b want %0b", i, pre_req, exp_req); end
            if (exp_req) begin
                checks++; if (pre_addr !== exp_addr) begin errors++; $display("FAIL rnd_addr cyc=%0d got %h want %h", i, pre_addr, exp_addr); end
            end
            checks++; if (valid_if !== m_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d got %0b want %0b", i, valid_if, m_valid); end
            checks++; if (instruction_if !== m_instr) begin errors++; $display("FAIL rnd_instr cyc=%0d got %h want %h", i, instruction_if, m_instr); end
            checks++; if (pc_if !== m_opc) begin errors++; $display("FAIL rnd_pc cyc=%0d got %h want %h", i, pc_if, m_opc); end
            checks++; if (next_program_counter_if !== m_npc) begin errors++; $display("FAIL rnd_npc cyc=%0d got %h want %h", i, next_program_counter_if, m_npc); end
            checks++; if (branch_prediction_if !== m_pred) begin errors++; $display("FAIL rnd_pred cyc=%0d got %0b want %0b", i, branch_prediction_if, m_pred); end
        end
        pred_mode = 0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_latency();
        test_prediction();
        test_stall_skid();
        test_flush_drain();
        test_flush_stall_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
